counter_arbiter: RTL
====================

# counter_arbiter

Round-robin arbiter and sequencer that shares one up/down counter register between up to NUM_REQ pulse requesters, such as debounced, edge-detected push buttons. Each requester has a fixed operation (increment, decrement, clear, load). Simultaneous or back-to-back requests are queued in per-requester pending flags, so they are serviced one per cycle and none are silently merged. The block sits between the button front-end (debounce and posedge detection) and the display or LED output logic.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- WIDTH, 4: counter width in bits.
- OP_MAP, 8'b11_10_01_00: 2 bits per requester. Bits [2i+1:2i] give the op of requester i: 00 inc, 01 dec, 10 clear, 11 load. The default maps req0=inc, req1=dec, req2=clear, req3=load.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  single-cycle request pulses, one bit per requester.
- load_val  in  WIDTH  value applied by a load op; sampled on the grant edge.
- count  out  WIDTH  counter value, registered.
- grant  out  NUM_REQ  one-hot pulse, high for the one cycle in which count shows the result of that requester's op.
- busy  out  1  high while any pending flag is set (OR of pending, registered).
- ovf  out  1  one-cycle pulse when an inc wraps from all-ones to 0, or a dec wraps from 0 to all-ones.
- lost  out  1  one-cycle pulse when a request is dropped.

## Operation
- Reset values: pending=0, count=0, grant=0, ovf=0, lost=0, busy=0, rr_last=NUM_REQ-1 (so requester 0 has first priority).
- Pending flags: on each edge, pending[i] is set when req[i]=1 and cleared when requester i is granted.
  - If req[i] arrives in the same cycle that pending[i] is granted, pending[i] stays set (the new request is queued).
  - If req[i] arrives while pending[i] is set and i is not granted that cycle, the request is dropped and lost pulses.
- Arbitration is combinational from the pending register. It searches indices rr_last+1, rr_last+2, … modulo NUM_REQ and selects the first set pending bit.
  - On a grant, rr_last takes the granted index.
  - With no pending bits, nothing is granted and rr_last holds.
- Ops, applied on the grant edge:
  - inc: count+1, modulo 2^WIDTH.
  - dec: count-1, modulo 2^WIDTH.
  - clear: count=0.
  - load: count=load_val.
- ovf is produced only by inc/dec wrap. clear and load never set ovf.
- At most one op per cycle. A requester with no pending flag can never be granted.

## Timing
- A req pulse sampled at edge E0 sets pending after E0. The earliest grant is at edge E1.
- After E1, count holds the new value and grant[i] is high for exactly one cycle.
- Request-to-count latency is 2 edges when uncontended.
- With k requesters pending at once, all k are serviced on k consecutive edges in round-robin order. grant is high on each of those k cycles and busy falls on the cycle after the last grant.
- busy, ovf and lost are registered and aligned with the grant/count update they describe. lost is aligned with the edge that samples the dropped req.
- Reset asserted mid-sequence immediately forces all outputs and pending flags to their reset values. Queued requests are discarded. Requests resume being sampled on the first edge after rst deasserts.

## Configuration
- COUNTER_ARB_SATURATE_EN:
  - Defined: inc at all-ones holds all-ones, and dec at 0 holds 0. ovf still pulses on such a blocked attempt, and the grant still occurs.
  - Undefined: inc and dec wrap modulo 2^WIDTH, as described above.

## Test plan
- Single req[0] pulse from count=0 → grant=0001 one cycle after pending is set; count=1; busy high for 1 cycle; ovf=0.
- req=1111 in one cycle with load_val=9, count=5 → grants 0001, 0010, 0100, 1000 on 4 consecutive cycles; count sequence 6, 5, 0, 9; busy falls after the 4th grant.
- req[1] pulsed on two consecutive cycles while req[0] is pending → first req[1] serviced after req[0]; second req[1] raises lost=1, so only one dec is applied.
- count=15, req[0] → count=0 with ovf=1. With COUNTER_ARB_SATURATE_EN defined → count=15 with ovf=1.
- req=0011 then rst asserted for 1 cycle between the two grants → count=0, pending=0, grant=0 immediately. No further grants occur. A fresh req[0] after release is granted first (rr_last reset).
- Continuous req[0] and req[1] pulses every cycle → grants alternate 0001/0010 each cycle; lost pulses on the non-granted requester's repeat; neither requester is starved.

Source files
------------

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin sequencer sharing one up/down counter among NUM_REQ pulse requesters.
// Optional build macro COUNTER_ARB_SATURATE_EN: inc/dec saturate instead of wrapping (ovf still pulses).
module counter_arbiter #(
  parameter int                   NUM_REQ = 4,
  parameter int                   WIDTH   = 4,
  parameter logic [2*NUM_REQ-1:0] OP_MAP  = 8'b11_10_01_00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   count,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               ovf,
  output logic               lost
);

  localparam int                IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [WIDTH-1:0]  ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]  ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  logic [NUM_REQ-1:0] pending_r;
  logic [NUM_REQ-1:0] pending_s;
  logic [NUM_REQ-1:0] sel_s;
  logic [NUM_REQ-1:0] lost_vec_s;
  logic [IW-1:0]      rr_last_r;
  logic [IW-1:0]      sel_idx_s;
  logic               found_s;
  op_e                op_s;
  logic [WIDTH-1:0]   count_s;
  logic               ovf_s;

  // Round-robin search over the pending flags, starting just after the last granted index
  always_comb begin
    logic [IW-1:0] idx_v;
    logic          hit_v;
    sel_s     = {NUM_REQ{1'b0}};
    sel_idx_s = rr_last_r;
    found_s   = 1'b0;
    idx_v     = {IW{1'b0}};
    hit_v     = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_v        = IW'((int'(rr_last_r) + k) % NUM_REQ);
      hit_v        = pending_r[idx_v] & ~found_s;
      sel_s[idx_v] = sel_s[idx_v] | hit_v;
      sel_idx_s    = hit_v ? idx_v : sel_idx_s;
      found_s      = found_s | hit_v;
    end
  end

  // A req landing on a still-pending, ungranted flag is dropped; one landing on the granted flag is queued
  always_comb begin
    pending_s  = (pending_r & ~sel_s) | req;
    lost_vec_s = req & pending_r & ~sel_s;
    op_s       = op_e'(OP_MAP[{sel_idx_s, 1'b0} +: 2]);
  end

  // Counter update for the granted requester's op; only inc/dec at the range limits raise ovf
  always_comb begin
    count_s = count;
    ovf_s   = 1'b0;
    if (found_s) begin
      case (op_s)
        OP_INC: begin
          if (count == ALL_ONES) begin
            ovf_s = 1'b1;
`ifdef COUNTER_ARB_SATURATE_EN
            count_s = ALL_ONES;
`else
            count_s = ZERO;
`endif
          end else begin
            count_s = count + ONE;
          end
        end
        OP_DEC: begin
          if (count == ZERO) begin
            ovf_s = 1'b1;
`ifdef COUNTER_ARB_SATURATE_EN
            count_s = ZERO;
`else
            count_s = ALL_ONES;
`endif
          end else begin
            count_s = count - ONE;
          end
        end
        OP_CLR:  count_s = ZERO;
        OP_LOAD: count_s = load_val;
        default: count_s = count;
      endcase
    end else begin
      count_s = count;
    end
  end

  // State and registered outputs; busy reflects the pending set seen by this edge's arbitration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_REQ{1'b0}};
      rr_last_r <= LAST_IDX;
      count     <= ZERO;
      grant     <= {NUM_REQ{1'b0}};
      busy      <= 1'b0;
      ovf       <= 1'b0;
      lost      <= 1'b0;
    end else begin
      pending_r <= pending_s;
      rr_last_r <= found_s ? sel_idx_s : rr_last_r;
      count     <= count_s;
      grant     <= sel_s;
      busy      <= |pending_r;
      ovf       <= ovf_s;
      lost      <= |lost_vec_s;
    end
  end

endmodule
